// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
// Optional feature macro: UART_ARB_HEADER_EN (prefix each frame with HDR_BASE|grant_id).
package uart_arb_pkg;

    // Arbiter FSM states; HEADER is only reachable when UART_ARB_HEADER_EN is defined.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Base value of the frame header byte; the granted index is OR-ed into the low bits.
    localparam logic [7:0] HDR_BASE = 8'hA0;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap-around.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int NB_ID = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [NB_ID-1:0] ptr,
    output logic             valid,
    output logic [NB_ID-1:0] idx
);

    logic [NB_ID-1:0] pos;

    // Scan from the farthest offset down so the offset closest to ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = NB_ID'((int'(ptr) + i) % N_REQ);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte-stream requesters share one UART TX FIFO.
// A granted requester owns the FIFO until it writes a byte flagged i_last, or until it
// leaves TIMEOUT non-stalled cycles without presenting a byte (o_abort pulse).
// Optional feature macro: UART_ARB_HEADER_EN adds a HEADER state that writes
// HDR_BASE|grant_id ahead of every frame.
//
// Handshake: a byte is transferred on every rising edge where wr_uart=1. In PAYLOAD,
// wr_uart = i_req[g] & ~tx_full and o_ack[g] mirrors wr_uart in the same cycle, so the
// requester must hold i_data/i_last stable until it sees o_ack; tx_full=1 is pure stall.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int N_REQ      = 4,
    parameter int NB_ID      = 2,
    parameter int TIMEOUT    = 255,
    parameter int NB_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_last,
    input  logic [N_REQ*NB_DATA-1:0] i_data,
    output logic [N_REQ-1:0]         o_ack,
    input  logic                     tx_full,
    output logic                     wr_uart,
    output logic [NB_DATA-1:0]       o_data,
    output logic                     o_busy,
    output logic [NB_ID-1:0]         o_grant_id,
    output logic                     o_abort,
    output logic [1:0]               dbg_state,
    output logic [NB_ID-1:0]         dbg_rr_ptr
);

    state_t                state;
    logic [NB_ID-1:0]      rr_ptr;
    logic [NB_ID-1:0]      grant_id;
    logic [NB_TIMEOUT-1:0] to_cnt;

    logic                  pick_valid;
    logic [NB_ID-1:0]      pick_idx;
    logic                  g_req;
    logic                  g_last;
    logic [NB_DATA-1:0]    g_data;
    logic [NB_ID-1:0]      next_ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .NB_ID (NB_ID)
    ) u_picker (
        .req   (i_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign g_req      = i_req[grant_id];
    assign g_last     = i_last[grant_id];
    assign g_data     = i_data[grant_id*NB_DATA +: NB_DATA];
    assign next_ptr   = (grant_id == NB_ID'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign o_grant_id = grant_id;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

    // FIFO write path is combinational so a byte is accepted in the cycle it is presented.
    always_comb begin
        wr_uart = 1'b0;
        o_data  = '0;
        o_ack   = '0;
        case (state)
`ifdef UART_ARB_HEADER_EN
            HEADER: begin
                wr_uart = ~tx_full;
                o_data  = NB_DATA'(HDR_BASE) | NB_DATA'(grant_id);
            end
`endif
            PAYLOAD: begin
                wr_uart = g_req & ~tx_full;
                o_data  = g_data;
                if (g_req && !tx_full) begin
                    o_ack = N_REQ'(1) << grant_id;
                end
            end
            default: ;
        endcase
    end

    // Grant, frame tracking, idle timeout and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            to_cnt   <= '0;
            o_busy   <= 1'b0;
            o_abort  <= 1'b0;
        end else begin
            o_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        to_cnt   <= '0;
                        o_busy   <= 1'b1;
`ifdef UART_ARB_HEADER_EN
                        state    <= HEADER;
`else
                        state    <= PAYLOAD;
`endif
                    end
                end
`ifdef UART_ARB_HEADER_EN
                HEADER: begin
                    if (!tx_full) begin
                        state <= PAYLOAD;
                    end
                end
`endif
                PAYLOAD: begin
                    if (g_req && !tx_full) begin
                        to_cnt <= '0;
                        if (g_last) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!g_req && !tx_full) begin
                        // Stalled cycles (tx_full=1) never count toward the timeout.
                        if (to_cnt == NB_TIMEOUT'(TIMEOUT - 1)) begin
                            to_cnt  <= '0;
                            o_abort <= 1'b1;
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                            rr_ptr  <= next_ptr;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter (default parameters).
module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int NB_DATA = 8;
    localparam int NB_ID   = 2;
    localparam int MAXB    = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_REQ-1:0]         i_req;
    logic [N_REQ-1:0]         i_last;
    logic [N_REQ*NB_DATA-1:0] i_data;
    logic [N_REQ-1:0]         o_ack;
    logic                     tx_full;
    logic                     wr_uart;
    logic [NB_DATA-1:0]       o_data;
    logic                     o_busy;
    logic [NB_ID-1:0]         o_grant_id;
    logic                     o_abort;
    logic [1:0]               dbg_state;
    logic [NB_ID-1:0]         dbg_rr_ptr;

    int n_checks = 0;
    int n_errors = 0;

    // Expected FIFO writes: {is_header, owner[1:0], data[7:0]}
    logic [10:0] exp_q[$];

    // Requester frame storage for the randomized phase
    logic [7:0] rq_bytes [N_REQ][MAXB];
    logic       rq_last  [N_REQ][MAXB];
    int         rq_len   [N_REQ];
    int         rq_pos   [N_REQ];
    int         rq_gap   [N_REQ];

    // Clock and reset
    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_last     (i_last),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .o_data     (o_data),
        .o_busy     (o_busy),
        .o_grant_id (o_grant_id),
        .o_abort    (o_abort),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: change inputs at the falling edge, let combinational outputs settle.
    task automatic drive(input logic [3:0] req, input logic [3:0] last,
                         input logic [31:0] data, input logic full);
        @(negedge clk);
        i_req   = req;
        i_last  = last;
        i_data  = data;
        tx_full = full;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        i_req = '0; i_last = '0; i_data = '0; tx_full = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Hold inputs and wait (bounded) for any o_ack pulse.
    task automatic wait_ack(input int bound, output bit found);
        found = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (o_ack != '0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    // Header byte precedes the payload only when the optional header is compiled in.
    task automatic hdr_step(input int id);
`ifdef UART_ARB_HEADER_EN
        check("hdr_wr", wr_uart, 1);
        check("hdr_data", o_data, 32'hA0 | id);
        check("hdr_no_ack", o_ack, 0);
        @(negedge clk);
        #1;
`else
        if (id < 0) $display("unused header id %0d", id);
`endif
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n_idle;
        int ptr;
        int k;
        int nb;
        int fpos [N_REQ];
        logic [10:0] e;

        reset = 1'b1; i_req = '0; i_last = '0; i_data = '0; tx_full = 1'b0;

        // ---- reset values
        #2;
        check("rst_wr", wr_uart, 0);
        check("rst_ack", o_ack, 0);
        check("rst_busy", o_busy, 0);
        check("rst_abort", o_abort, 0);
        check("rst_data", o_data, 0);
        check("rst_grant", o_grant_id, 0);
        check("rst_state", dbg_state, uart_arb_pkg::IDLE);
        @(negedge clk);
        reset = 1'b0;

        // ---- single frame from requester 0: 11, 22, 33(last)
        drive(4'b0001, 4'b0000, 32'h11, 1'b0);
        check("idle_no_wr", wr_uart, 0);
        check("idle_no_busy", o_busy, 0);
        drive(4'b0001, 4'b0000, 32'h11, 1'b0);
        hdr_step(0);
        check("sf_busy", o_busy, 1);
        check("sf_grant", o_grant_id, 0);
        check("sf_b0_wr", wr_uart, 1);
        check("sf_b0_data", o_data, 32'h11);
        check("sf_b0_ack", o_ack, 4'b0001);
        drive(4'b0001, 4'b0000, 32'h22, 1'b0);
        check("sf_b1_data", o_data, 32'h22);
        check("sf_b1_ack", o_ack, 4'b0001);
        drive(4'b0001, 4'b0001, 32'h33, 1'b0);
        check("sf_b2_data", o_data, 32'h33);
        check("sf_b2_ack", o_ack, 4'b0001);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        check("sf_end_busy", o_busy, 0);
        check("sf_end_wr", wr_uart, 0);
        check("sf_rr_ptr", dbg_rr_ptr, 1);

        // ---- backpressure on requester 1
        drive(4'b0010, 4'b0000, 32'h4400, 1'b0);
        drive(4'b0010, 4'b0000, 32'h4400, 1'b0);
        hdr_step(1);
        check("bp_b0_data", o_data, 32'h44);
        check("bp_b0_ack", o_ack, 4'b0010);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0010, 4'b0010, 32'h5500, 1'b1);
            check("bp_stall_wr", wr_uart, 0);
            check("bp_stall_ack", o_ack, 0);
            check("bp_stall_abort", o_abort, 0);
            check("bp_stall_busy", o_busy, 1);
        end
        drive(4'b0010, 4'b0010, 32'h5500, 1'b0);
        check("bp_resume_wr", wr_uart, 1);
        check("bp_resume_data", o_data, 32'h55);
        check("bp_resume_ack", o_ack, 4'b0010);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        check("bp_end_busy", o_busy, 0);
        check("bp_rr_ptr", dbg_rr_ptr, 2);

        // ---- fairness: all request, 1-byte frames, expect 0,1,2,3,0
        pulse_reset();
        @(negedge clk);
        i_req = 4'b1111; i_last = 4'b1111; i_data = 32'hC3C2C1C0;
        #1;
        for (int f = 0; f < 5; f++) begin
            wait_ack(6, found);
            check("fair_found", found, 1);
            check("fair_ack", o_ack, 32'h1 << (f % 4));
            check("fair_grant", o_grant_id, f % 4);
            check("fair_data", o_data, 32'hC0 + (f % 4));
            if (f < 4) begin
                @(negedge clk);
                #1;
            end else begin
                drive(4'b0000, 4'b0000, 32'h0, 1'b0);
            end
        end
        check("fair_rr_ptr", dbg_rr_ptr, 1);

        // ---- timeout: requester 2 sends one byte, then goes silent
        drive(4'b0100, 4'b0000, 32'h0077_0000, 1'b0);
        wait_ack(6, found);
        check("to_found", found, 1);
        check("to_grant", o_grant_id, 2);
        check("to_data", o_data, 32'h77);
        n_idle = 0;
        for (int c = 0; c < 400; c++) begin
            drive(4'b0000, 4'b0000, 32'h0, 1'b0);
            n_idle++;
            if (o_abort) break;
        end
        check("to_abort_seen", o_abort, 1);
        check("to_idle_cycles", n_idle - 1, 255);
        check("to_busy", o_busy, 0);
        check("to_state", dbg_state, uart_arb_pkg::IDLE);
        check("to_rr_ptr", dbg_rr_ptr, 3);
        drive(4'b1001, 4'b1001, 32'h9300_0090, 1'b0);
        check("to_abort_pulse", o_abort, 0);
        wait_ack(6, found);
        check("to_next_found", found, 1);
        check("to_next_grant", o_grant_id, 3);
        check("to_next_ack", o_ack, 4'b1000);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);

        // ---- reset mid-frame
        drive(4'b0010, 4'b0000, 32'h6600, 1'b0);
        wait_ack(6, found);
        check("mr_found", found, 1);
        @(negedge clk);
        i_data = 32'h6700;
        #1;
        check("mr_pre_wr", wr_uart, 1);
        #1;
        reset = 1'b1;
        #1;
        check("mr_wr", wr_uart, 0);
        check("mr_ack", o_ack, 0);
        check("mr_busy", o_busy, 0);
        check("mr_abort", o_abort, 0);
        check("mr_data", o_data, 0);
        check("mr_grant", o_grant_id, 0);
        check("mr_state", dbg_state, uart_arb_pkg::IDLE);
        @(negedge clk);
        reset = 1'b0;
        #1;
        wait_ack(6, found);
        check("mr_regrant_found", found, 1);
        check("mr_regrant_id", o_grant_id, 1);
        check("mr_regrant_ack", o_ack, 4'b0010);

        // ---- randomized frames against a round-robin reference model
        pulse_reset();
        for (int r = 0; r < N_REQ; r++) begin
            nb = 0;
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    rq_bytes[r][nb] = 8'($urandom);
                    rq_last[r][nb]  = (b == len - 1);
                    nb++;
                end
            end
            for (int b = nb; b < MAXB; b++) begin
                rq_bytes[r][b] = 8'h00;
                rq_last[r][b]  = 1'b0;
            end
            rq_len[r] = nb;
            rq_pos[r] = 0;
            rq_gap[r] = 0;
            fpos[r]   = 0;
        end
        // Every requester keeps its request up until all its frames are sent, so the
        // serving order is the plain round-robin walk over requesters with frames left.
        ptr = 0;
        forever begin
            k = -1;
            for (int o = 0; o < N_REQ; o++) begin
                if (k < 0 && fpos[(ptr + o) % N_REQ] < rq_len[(ptr + o) % N_REQ])
                    k = (ptr + o) % N_REQ;
            end
            if (k < 0) break;
`ifdef UART_ARB_HEADER_EN
            exp_q.push_back({1'b1, 2'(k), 8'hA0 | 8'(k)});
`endif
            forever begin
                exp_q.push_back({1'b0, 2'(k), rq_bytes[k][fpos[k]]});
                fpos[k]++;
                if (rq_last[k][fpos[k] - 1]) break;
            end
            ptr = (k + 1) % N_REQ;
        end

        for (int cyc = 0; cyc < 3000 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < N_REQ; r++) begin
                i_req[r]                   = (rq_pos[r] < rq_len[r]) && (rq_gap[r] == 0);
                i_last[r]                  = rq_last[r][rq_pos[r]];
                i_data[r*NB_DATA +: NB_DATA] = rq_bytes[r][rq_pos[r]];
            end
            tx_full = ($urandom_range(0, 3) == 0);
            #1;
            check("rnd_no_abort", o_abort, 0);
            if (tx_full) check("rnd_stall_wr", wr_uart, 0);
            if (wr_uart) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra_wr", wr_uart, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_data", o_data, e[7:0]);
                    check("rnd_ack", o_ack, e[10] ? 32'h0 : (32'h1 << e[9:8]));
                end
            end else begin
                check("rnd_idle_ack", o_ack, 0);
            end
            for (int r = 0; r < N_REQ; r++) begin
                if (rq_gap[r] > 0) rq_gap[r]--;
                if (o_ack[r]) begin
                    if (!rq_last[r][rq_pos[r]] && $urandom_range(0, 2) == 0)
                        rq_gap[r] = int'($urandom_range(1, 5));
                    rq_pos[r]++;
                end
            end
        end
        check("rnd_drained", exp_q.size(), 0);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        check("rnd_end_busy", o_busy, 0);
        check("rnd_end_wr", wr_uart, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, meaning byte width.
REQ-002 SHALL have parameter N_REQ, default 4, meaning number of requesters.
REQ-003 SHALL have parameter NB_ID, default 2, meaning requester-index width, equal to clog2(N_REQ).
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum idle cycles allowed mid-frame.
REQ-005 SHALL have parameter NB_TIMEOUT, default 8, meaning the timeout counter width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port i_req, input, N_REQ bits: per-requester "byte valid / frame pending".
REQ-009 SHALL have port i_last, input, N_REQ bits: the presented byte ends the frame.
REQ-010 SHALL have port i_data, input, N_REQ*NB_DATA bits: requester k occupies bits [k*NB_DATA +: NB_DATA].
REQ-011 SHALL have port o_ack, output, N_REQ bits: one-hot pulse when the presented byte is accepted.
REQ-012 SHALL have port tx_full, input, 1 bit: the TX FIFO is full.
REQ-013 SHALL have port wr_uart, output, 1 bit: TX FIFO write strobe.
REQ-014 SHALL have port o_data, output, NB_DATA bits: TX FIFO write data.
REQ-015 SHALL have port o_busy, output, 1 bit: a frame is granted.
REQ-016 SHALL have port o_grant_id, output, NB_ID bits: index of the granted requester.
REQ-017 SHALL have port o_abort, output, 1 bit: one-cycle pulse on frame timeout.

Function
REQ-018 SHALL implement states IDLE, HEADER, PAYLOAD.
REQ-019 In IDLE with any i_req high, SHALL grant the first requester with req high, searching from rr_ptr upward with wrap-around, then register o_grant_id.
- Next state is HEADER when UART_ARB_HEADER_EN is defined, otherwise PAYLOAD.
- Grant latency is 1 cycle.
REQ-020 In IDLE, SHALL keep wr_uart=0 and o_ack=0.
REQ-021 In HEADER, SHALL drive wr_uart=~tx_full and o_data=HDR_BASE|grant_id.
- Advances to PAYLOAD on the cycle the write occurs.
- No o_ack in HEADER.
REQ-022 In PAYLOAD, SHALL drive wr_uart=i_req[g]&~tx_full, o_data=i_data[g], and o_ack[g]=wr_uart, all combinational from the inputs.
REQ-023 A PAYLOAD write with i_last[g]=1 SHALL return to IDLE and set rr_ptr=g+1 modulo N_REQ.
REQ-024 While tx_full=1, SHALL write nothing and hold state; data presented by the requester SHALL be held by the requester.
REQ-025 In PAYLOAD with i_req[g]=0, SHALL increment the timeout counter, which clears on every write.
- When the counter reaches TIMEOUT: pulse o_abort, go to IDLE, set rr_ptr=g+1.
REQ-026 Cycles stalled by tx_full SHALL NOT advance the timeout counter.
REQ-027 Requests from non-granted requesters SHALL be ignored until the frame ends; their o_ack SHALL stay 0.
REQ-028 o_busy SHALL be 1 in HEADER and PAYLOAD, and 0 in IDLE.
REQ-029 A frame of one byte (i_last on the first byte) SHALL be legal.
REQ-030 A new grant SHALL be made no earlier than the cycle after returning to IDLE.

Reset
REQ-031 Asserting reset SHALL asynchronously force the following, including mid-frame:
- state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0;
- wr_uart=0, o_ack=0, o_busy=0, o_abort=0, o_data=0.
REQ-032 After reset deasserts, the first grant SHALL follow REQ-019 with rr_ptr=0.

Configuration
REQ-033 Macro UART_ARB_HEADER_EN, when defined, SHALL compile in the HEADER state, so each frame is prefixed with byte HDR_BASE|grant_id.
REQ-034 Without UART_ARB_HEADER_EN, SHALL contain no HEADER state; IDLE goes directly to PAYLOAD.

Structure
REQ-035 Package uart_arb_pkg SHALL hold the state enum (IDLE/HEADER/PAYLOAD) and constant HDR_BASE=8'hA0.
REQ-036 Round-robin selection SHALL live in combinational sub-module rr_picker, which takes (req, ptr) and returns (valid, idx).

Verification
REQ-037 Single frame: req0 sends 0x11, 0x22, 0x33 (last) with tx_full=0 -> wr_uart for 3 cycles with the same data, 3 o_ack[0] pulses, o_busy drops, rr_ptr=1.
REQ-038 Fairness: i_req=4'b1111 held, each requester sends 1-byte frames -> grant order 0,1,2,3,0.
REQ-039 Backpressure: tx_full=1 for 5 cycles mid-frame -> no wr_uart, no o_ack, no abort; data resumes unchanged after tx_full drops.
REQ-040 Timeout: req2 granted sends 1 byte, then drops req -> o_abort pulses after 255 idle cycles, state returns to IDLE, next grant searches from 3.
REQ-041 Header (UART_ARB_HEADER_EN defined): req3 sends 0x55 (last) -> wr_uart bytes 0xA3, then 0x55.
REQ-042 Reset mid-frame: assert reset during PAYLOAD -> all outputs 0 immediately; after release, req1 alone is granted.
